split_burst_resp: RTL and testbench

- Write-response side counterpart of the burst detector.
- The burst detector merges consecutive addresses into one AXI burst and pushes the burst length (0-based) to a side FIFO. The AXI B channel then returns one response per burst.
- This block pairs each burst length with its single B response. It re-expands the pair into burst_len+1 per-element responses, so the upstream kernel sees exactly one ack per original address.
- Sits between the AXI B-channel FIFO / burst_len side FIFO and the kernel's write-response FIFO.

---
 rtl/split_burst_resp_pkg.sv | 17 +
 rtl/split_burst_resp.sv | 84 ++++++++
 tb/tb_split_burst_resp.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_burst_resp_pkg.sv
// Shared types and AXI BRESP codes for the split_burst_resp write-response expander.
package split_burst_resp_pkg;

  localparam int RESP_WIDTH    = 2;
  localparam int ERR_CNT_WIDTH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'd0;
  localparam logic [RESP_WIDTH-1:0] RESP_EXOKAY = 2'd1;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'd2;
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/split_burst_resp.sv
// Re-expands one AXI B response per burst into burst_len+1 per-element acks.
// Optional error counter enabled by defining SPLIT_BURST_RESP_ERR_CNT_EN.
module split_burst_resp
  import split_burst_resp_pkg::*;
#(
  parameter int BurstLenWidth = 8,
  parameter int RespWidth     = RESP_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BurstLenWidth-1:0]             burst_len_dout,
  input  logic                                 burst_len_empty_n,
  output logic                                 burst_len_read,
  input  logic [RespWidth-1:0]                 resp_dout,
  input  logic                                 resp_empty_n,
  output logic                                 resp_read,
  output logic [BurstLenWidth+1+RespWidth-1:0] elem_resp_din,
  input  logic                                 elem_resp_full_n,
  output logic                                 elem_resp_write
`ifdef SPLIT_BURST_RESP_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0]             err_count
`endif
);

  state_e                   state;
  logic [BurstLenWidth-1:0] remain;
  logic [BurstLenWidth-1:0] beat_idx;
  logic [RespWidth-1:0]     resp_q;

  logic load;
  logic last_beat;
  logic accept;
  logic pop;

  assign load      = burst_len_empty_n && resp_empty_n;
  assign last_beat = (remain == '0);
  assign accept    = (state == EXPAND) && elem_resp_full_n;

  // Both FIFOs always pop together; the last accepted beat may reload with no bubble.
  assign pop = !rst && load && ((state == IDLE) || (accept && last_beat));

  assign burst_len_read  = pop;
  assign resp_read       = pop;
  assign elem_resp_write = !rst && accept;
  assign elem_resp_din   = {beat_idx, last_beat, resp_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      remain   <= '0;
      beat_idx <= '0;
      resp_q   <= '0;
    end else if (pop) begin
      state    <= EXPAND;
      remain   <= burst_len_dout;
      beat_idx <= '0;
      resp_q   <= resp_dout;
    end else if (accept) begin
      if (last_beat) begin
        state <= IDLE;
      end else begin
        remain   <= remain - 1'b1;
        beat_idx <= beat_idx + 1'b1;
      end
    end
  end

`ifdef SPLIT_BURST_RESP_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  // Counts popped non-OKAY responses, saturating rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (pop && (resp_dout != '0) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign err_count = err_cnt;
`endif

endmodule

// File: tb/tb_split_burst_resp.sv
// Self-checking bench for split_burst_resp: vector table, directed corner cases, random traffic.
module tb_split_burst_resp;

  localparam int BLW = 8;
  localparam int RW  = 2;
  localparam int DW  = BLW + 1 + RW;

  logic          clk = 1'b0;
  logic          rst;
  logic [BLW-1:0] burst_len_dout;
  logic          burst_len_empty_n;
  logic          burst_len_read;
  logic [RW-1:0] resp_dout;
  logic          resp_empty_n;
  logic          resp_read;
  logic [DW-1:0] elem_resp_din;
  logic          elem_resp_full_n;
  logic          elem_resp_write;
`ifdef SPLIT_BURST_RESP_ERR_CNT_EN
  logic [15:0]   err_count;
`endif

  split_burst_resp #(.BurstLenWidth(BLW), .RespWidth(RW)) dut (
    .clk               (clk),
    .rst               (rst),
    .burst_len_dout    (burst_len_dout),
    .burst_len_empty_n (burst_len_empty_n),
    .burst_len_read    (burst_len_read),
    .resp_dout         (resp_dout),
    .resp_empty_n      (resp_empty_n),
    .resp_read         (resp_read),
    .elem_resp_din     (elem_resp_din),
    .elem_resp_full_n  (elem_resp_full_n),
    .elem_resp_write   (elem_resp_write)
`ifdef SPLIT_BURST_RESP_ERR_CNT_EN
    ,
    .err_count         (err_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Input FIFO contents, expected element stream, and observation logs.
  logic [BLW-1:0] lenQ[$];
  logic [RW-1:0]  rspQ[$];
  logic [DW-1:0]  expQ[$];
  logic [DW-1:0]  wlogDin[$];
  int             wlogCyc[$];
  int             popLog[$];
  logic           fullN = 1'b1;
  int             errModel = 0;

  typedef struct {
    logic [BLW-1:0] len;
    logic [RW-1:0]  resp;
    int             expWrites;
    logic [DW-1:0]  expLastDin;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic driveInputs();
    burst_len_empty_n = (lenQ.size() > 0);
    burst_len_dout    = (lenQ.size() > 0) ? lenQ[0] : '0;
    resp_empty_n      = (rspQ.size() > 0);
    resp_dout         = (rspQ.size() > 0) ? rspQ[0] : '0;
    elem_resp_full_n  = fullN;
  endtask

  // One clock of traffic: drive, compare against the model, then advance past the edge.
  task automatic applyStimulus();
    logic           expPop;
    logic           expWr;
    logic [BLW-1:0] l;
    logic [RW-1:0]  r;
    driveInputs();
    #2;
    expPop = (lenQ.size() > 0) && (rspQ.size() > 0) &&
             ((expQ.size() == 0) || ((expQ.size() == 1) && fullN));
    expWr  = (expQ.size() > 0) && fullN;
    checkOutput("burst_len_read", burst_len_read, expPop);
    checkOutput("resp_read", resp_read, expPop);
    checkOutput("elem_resp_write", elem_resp_write, expWr);
    if (elem_resp_write) begin
      wlogDin.push_back(elem_resp_din);
      wlogCyc.push_back(cyc);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 32'(elem_resp_din), 32'hFFFF_FFFF);
      end else begin
        checkOutput("elem_resp_din", elem_resp_din, expQ.pop_front());
      end
    end
    if (burst_len_read && lenQ.size() > 0 && rspQ.size() > 0) begin
      l = lenQ.pop_front();
      r = rspQ.pop_front();
      for (int i = 0; i <= int'(l); i++) begin
        expQ.push_back({i[BLW-1:0], (i == int'(l)), r});
      end
      popLog.push_back(cyc);
      if (r != '0 && errModel < 65535) errModel++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runUntilIdle(input int budget, input string tag);
    int n = 0;
    while ((expQ.size() > 0 || (lenQ.size() > 0 && rspQ.size() > 0)) && n < budget) begin
      applyStimulus();
      n++;
    end
    if (expQ.size() > 0 || (lenQ.size() > 0 && rspQ.size() > 0)) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: still busy after %0d cycles, required idle", tag, budget);
    end
  endtask

  task automatic clearLogs();
    wlogDin.delete();
    wlogCyc.delete();
    popLog.delete();
  endtask

  // Asserts reset between clock edges and checks that every handshake drops at once.
  task automatic doReset();
    driveInputs();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_burst_len_read", burst_len_read, 1'b0);
    checkOutput("rst_resp_read", resp_read, 1'b0);
    checkOutput("rst_elem_resp_write", elem_resp_write, 1'b0);
`ifdef SPLIT_BURST_RESP_ERR_CNT_EN
    checkOutput("rst_err_count", err_count, 16'd0);
`endif
    expQ.delete();
    errModel = 0;
    clearLogs();
    @(posedge clk);
    #1;
    checkOutput("rst_hold_write", elem_resp_write, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'd3,   2'd0, 4,   {8'd3,   1'b1, 2'd0}};
    vecs[1] = '{8'd0,   2'd2, 1,   {8'd0,   1'b1, 2'd2}};
    vecs[2] = '{8'd255, 2'd3, 256, {8'd255, 1'b1, 2'd3}};
    vecs[3] = '{8'd1,   2'd1, 2,   {8'd1,   1'b1, 2'd1}};

    // Reset state with a pair already waiting: no pop may happen while rst is high.
    rst = 1'b1;
    lenQ.push_back(8'd2);
    rspQ.push_back(2'd0);
    driveInputs();
    #3;
    checkOutput("init_burst_len_read", burst_len_read, 1'b0);
    checkOutput("init_resp_read", resp_read, 1'b0);
    checkOutput("init_elem_resp_write", elem_resp_write, 1'b0);
`ifdef SPLIT_BURST_RESP_ERR_CNT_EN
    checkOutput("init_err_count", err_count, 16'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    runUntilIdle(50, "init_drain");

    // Table of single bursts with an always-ready output.
    for (int v = 0; v < 4; v++) begin
      clearLogs();
      lenQ.push_back(vecs[v].len);
      rspQ.push_back(vecs[v].resp);
      runUntilIdle(600, "vec_drain");
      checkOutput("vec_count", wlogDin.size(), vecs[v].expWrites);
      if (wlogDin.size() > 0 && popLog.size() > 0) begin
        checkOutput("vec_last_din", wlogDin[wlogDin.size()-1], vecs[v].expLastDin);
        checkOutput("vec_latency", wlogCyc[0] - popLog[0], 1);
        checkOutput("vec_consecutive", wlogCyc[wlogCyc.size()-1] - wlogCyc[0], vecs[v].expWrites - 1);
      end
    end

    // Back-to-back bursts pre-filled: three writes with no bubble.
    clearLogs();
    lenQ.push_back(8'd1); lenQ.push_back(8'd0);
    rspQ.push_back(2'd0); rspQ.push_back(2'd2);
    runUntilIdle(20, "b2b_drain");
    checkOutput("b2b_count", wlogDin.size(), 3);
    if (wlogDin.size() == 3) begin
      checkOutput("b2b_span", wlogCyc[2] - wlogCyc[0], 2);
      checkOutput("b2b_third", wlogDin[2], {8'd0, 1'b1, 2'd2});
    end

    // Backpressure after the first beat.
    clearLogs();
    lenQ.push_back(8'd2);
    rspQ.push_back(2'd1);
    for (int n = 0; n < 20 && wlogDin.size() < 1; n++) applyStimulus();
    fullN = 1'b0;
    lenQ.push_back(8'd0);
    rspQ.push_back(2'd3);
    repeat (5) applyStimulus();
    checkOutput("bp_no_write", wlogDin.size(), 1);
    checkOutput("bp_no_pop", popLog.size(), 1);
    fullN = 1'b1;
    runUntilIdle(20, "bp_drain");
    checkOutput("bp_count", wlogDin.size(), 4);
    if (wlogDin.size() == 4) begin
      checkOutput("bp_idx1", wlogDin[1], {8'd1, 1'b0, 2'd1});
      checkOutput("bp_idx2", wlogDin[2], {8'd2, 1'b1, 2'd1});
    end

    // Unpaired length: nothing moves until the response arrives.
    clearLogs();
    lenQ.push_back(8'd4);
    repeat (10) applyStimulus();
    checkOutput("unpaired_pops", popLog.size(), 0);
    checkOutput("unpaired_writes", wlogDin.size(), 0);
    rspQ.push_back(2'd0);
    runUntilIdle(20, "unpaired_drain");
    checkOutput("unpaired_pops_after", popLog.size(), 1);
    checkOutput("unpaired_writes_after", wlogDin.size(), 5);

    // Asynchronous reset while beat 3 of an 8-beat burst is presented.
    clearLogs();
    lenQ.push_back(8'd7);
    rspQ.push_back(2'd0);
    for (int n = 0; n < 20 && wlogDin.size() < 3; n++) applyStimulus();
    checkOutput("mid_idx3_present", elem_resp_din, {8'd3, 1'b0, 2'd0});
    lenQ.push_back(8'd1);
    rspQ.push_back(2'd2);
    doReset();
    runUntilIdle(20, "post_reset_drain");
    checkOutput("post_reset_count", wlogDin.size(), 2);
    if (wlogDin.size() == 2) checkOutput("post_reset_first", wlogDin[0], {8'd0, 1'b0, 2'd2});

    // Randomized traffic with random backpressure and independent FIFO arrivals.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0 && lenQ.size() < 8)
        lenQ.push_back(($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0 && rspQ.size() < 8)
        rspQ.push_back(2'($urandom_range(0, 3)));
      fullN = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    fullN = 1'b1;
    while (lenQ.size() < rspQ.size()) lenQ.push_back(8'd0);
    while (rspQ.size() < lenQ.size()) rspQ.push_back(2'd0);
    runUntilIdle(5000, "random_drain");
`ifdef SPLIT_BURST_RESP_ERR_CNT_EN
    checkOutput("random_err_count", err_count, 16'(errModel));

    // Error counting from a clean start, then saturation.
    doReset();
    lenQ.push_back(8'd0); lenQ.push_back(8'd0); lenQ.push_back(8'd0); lenQ.push_back(8'd0);
    rspQ.push_back(2'd0); rspQ.push_back(2'd2); rspQ.push_back(2'd3); rspQ.push_back(2'd0);
    runUntilIdle(20, "err_seq_drain");
    checkOutput("err_count_seq", err_count, 16'd2);
    for (int n = 0; n < 65535; n++) begin
      lenQ.push_back(8'd0);
      rspQ.push_back(2'd3);
    end
    runUntilIdle(70000, "err_sat_drain");
    checkOutput("err_count_sat", err_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
